window_comparator: RTL and testbench

Registered, multi-channel window comparator for the VGA controller. It checks one N-bit sample stream, such as a horizontal or vertical pixel counter, against CH independently programmable [lo, hi] windows. For each channel it reports inside, below and above flags with fixed two-cycle latency. Downstream it drives sprite, border and cursor region enables. It generalises the single-pair equality/ordering compare to per-channel ranges, signed operation, wrap-around windows and optional enter/exit pulses.

---
 rtl/window_comparator.sv | 158 +++++++++++++++
 tb/tb_window_comparator.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/window_comparator.sv
// window_comparator: registered multi-channel window comparator.
// One N-bit sample stream is checked against CH programmable [lo, hi]
// windows. Each channel reports in_win / below / above with a fixed
// two-cycle latency. A window with lo > hi wraps around the end of the range.
// Optional feature macro: WINCMP_EDGE_EN adds the per-channel enter/exit
// pulses and the history registers that drive them.
module window_comparator #(
  parameter int N      = 10,
  parameter int CH     = 4,
  parameter int SIGNED = 0,
  localparam int CW    = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [CW-1:0] cfg_ch,
  input  logic [N-1:0]  cfg_lo,
  input  logic [N-1:0]  cfg_hi,
  input  logic          in_valid,
  input  logic [N-1:0]  in_value,
  output logic          out_valid,
  output logic [CH-1:0] in_win,
  output logic [CH-1:0] below,
  output logic [CH-1:0] above
`ifdef WINCMP_EDGE_EN
  ,
  output logic [CH-1:0] enter,
  output logic [CH-1:0] exit
`endif
);

  // Per-channel bounds.
  logic [N-1:0]  r_lo [CH];
  logic [N-1:0]  r_hi [CH];

  // Raw compares of the incoming sample against the current bounds.
  logic [CH-1:0] w_ge_lo;
  logic [CH-1:0] w_le_hi;
  logic [CH-1:0] w_wrap;

  // Stage 1 registers.
  logic          r_s1_valid;
  logic [CH-1:0] r_s1_ge_lo;
  logic [CH-1:0] r_s1_le_hi;
  logic [CH-1:0] r_s1_wrap;

  // Stage 2 combine and output registers.
  logic [CH-1:0] w_in;
  logic [CH-1:0] w_below;
  logic [CH-1:0] w_above;
  logic          r_out_valid;
  logic [CH-1:0] r_in_win;
  logic [CH-1:0] r_below;
  logic [CH-1:0] r_above;

  // Bound registers: a write to channel c lands only when cfg_ch equals c,
  // so indices >= CH never match any channel and are silently dropped.
  // NOTE: the bound array is small and its reset value is architecturally
  // visible (full-range windows), so it is reset like any other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        r_lo[c] <= '0;
        r_hi[c] <= '1;
      end
    end else if (cfg_we) begin
      for (int c = 0; c < CH; c++) begin
        if (cfg_ch == CW'(c)) begin
          // NOTE: non-blocking assignment keeps the old bounds visible to
          // the sample compared in this same cycle.
          r_lo[c] <= cfg_lo;
          r_hi[c] <= cfg_hi;
        end
      end
    end
  end

  // Raw N-bit compares, signed or unsigned by elaboration-time choice.
  for (genvar c = 0; c < CH; c++) begin : g_cmp
    if (SIGNED != 0) begin : g_signed
      assign w_ge_lo[c] = $signed(in_value) >= $signed(r_lo[c]);
      assign w_le_hi[c] = $signed(in_value) <= $signed(r_hi[c]);
      assign w_wrap[c]  = $signed(r_lo[c])  >  $signed(r_hi[c]);
    end else begin : g_unsigned
      assign w_ge_lo[c] = in_value >= r_lo[c];
      assign w_le_hi[c] = in_value <= r_hi[c];
      assign w_wrap[c]  = r_lo[c]  >  r_hi[c];
    end
  end

  // Stage 1: capture valid and the raw compares.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_ge_lo <= '0;
      r_s1_le_hi <= '0;
      r_s1_wrap  <= '0;
    end else begin
      r_s1_valid <= in_valid;
      r_s1_ge_lo <= w_ge_lo;
      r_s1_le_hi <= w_le_hi;
      r_s1_wrap  <= w_wrap;
    end
  end

  // Stage 2 combine: normal windows need both compares, wrap windows either;
  // below/above only exist for normal windows. Flags are zero without valid.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // can leave one unassigned and infer a latch.
    w_in    = '0;
    w_below = '0;
    w_above = '0;
    if (r_s1_valid) begin
      w_in    = (r_s1_wrap & (r_s1_ge_lo | r_s1_le_hi)) |
                (~r_s1_wrap & r_s1_ge_lo & r_s1_le_hi);
      w_below = ~r_s1_wrap & ~r_s1_ge_lo;
      w_above = ~r_s1_wrap & ~r_s1_le_hi;
    end
  end

  // Stage 2: register the final flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_in_win    <= '0;
      r_below     <= '0;
      r_above     <= '0;
    end else begin
      r_out_valid <= r_s1_valid;
      r_in_win    <= w_in;
      r_below     <= w_below;
      r_above     <= w_above;
    end
  end

  assign out_valid = r_out_valid;
  assign in_win    = r_in_win;
  assign below     = r_below;
  assign above     = r_above;

`ifdef WINCMP_EDGE_EN
  logic [CH-1:0] r_prev;

  // History of in_win from the last valid output; bubbles leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= '0;
    end else if (r_out_valid) begin
      r_prev <= r_in_win;
    end
  end

  assign enter = {CH{r_out_valid}} &  r_in_win & ~r_prev;
  assign exit  = {CH{r_out_valid}} & ~r_in_win &  r_prev;
`endif

endmodule

// File: tb/tb_window_comparator.sv
// Testbench for window_comparator: table-driven stream on an unsigned
// N=10/CH=4 instance, plus hand-written reset and signed N=8/CH=3 sequences.
// Enter/exit checks are compiled in only with WINCMP_EDGE_EN.
module tb_window_comparator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Unsigned instance signals.
  logic       u_we = 1'b0;
  logic [1:0] u_ch = '0;
  logic [9:0] u_lo = '0, u_hi = '0;
  logic       u_iv = 1'b0;
  logic [9:0] u_val = '0;
  logic       u_ov;
  logic [3:0] u_in, u_bl, u_ab, u_en, u_ex;

  // Signed instance signals.
  logic       s_we = 1'b0;
  logic [1:0] s_ch = '0;
  logic [7:0] s_lo = '0, s_hi = '0;
  logic       s_iv = 1'b0;
  logic [7:0] s_val = '0;
  logic       s_ov;
  logic [2:0] s_in, s_bl, s_ab, s_en, s_ex;

`ifndef WINCMP_EDGE_EN
  assign u_en = '0;
  assign u_ex = '0;
  assign s_en = '0;
  assign s_ex = '0;
`endif

  window_comparator #(.N(10), .CH(4), .SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(u_we), .cfg_ch(u_ch), .cfg_lo(u_lo), .cfg_hi(u_hi),
    .in_valid(u_iv), .in_value(u_val),
    .out_valid(u_ov), .in_win(u_in), .below(u_bl), .above(u_ab)
`ifdef WINCMP_EDGE_EN
    , .enter(u_en), .exit(u_ex)
`endif
  );

  window_comparator #(.N(8), .CH(3), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(s_we), .cfg_ch(s_ch), .cfg_lo(s_lo), .cfg_hi(s_hi),
    .in_valid(s_iv), .in_value(s_val),
    .out_valid(s_ov), .in_win(s_in), .below(s_bl), .above(s_ab)
`ifdef WINCMP_EDGE_EN
    , .enter(s_en), .exit(s_ex)
`endif
  );

  typedef struct {
    logic       we;
    logic [1:0] ch;
    logic [9:0] lo;
    logic [9:0] hi;
    logic       v;
    logic [9:0] val;
    logic [3:0] ein;
    logic [3:0] ebl;
    logic [3:0] eab;
    logic [3:0] een;
    logic [3:0] eex;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  function automatic vec_t row(input logic we, input int ch, input int lo,
                               input int hi, input logic v, input int val,
                               input logic [3:0] ein, input logic [3:0] ebl,
                               input logic [3:0] eab, input logic [3:0] een,
                               input logic [3:0] eex);
    vec_t r;
    r.we = we; r.ch = 2'(ch); r.lo = 10'(lo); r.hi = 10'(hi);
    r.v = v; r.val = 10'(val);
    r.ein = ein; r.ebl = ebl; r.eab = eab; r.een = een; r.eex = eex;
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One signed sample in isolation; result checked two cycles later.
  task automatic s_sample(input string nm, input logic [7:0] v,
                          input logic [2:0] ein, input logic [2:0] ebl,
                          input logic [2:0] eab);
    @(negedge clk);
    s_iv = 1'b1; s_val = v;
    @(negedge clk);
    s_iv = 1'b0;
    @(negedge clk);
    check({nm, " out_valid"}, 32'(s_ov), 32'd1);
    check({nm, " in_win"},    32'(s_in), 32'(ein));
    check({nm, " below"},     32'(s_bl), 32'(ebl));
    check({nm, " above"},     32'(s_ab), 32'(eab));
  endtask

  task automatic s_write(input logic [1:0] ch, input logic [7:0] lo,
                         input logic [7:0] hi);
    @(negedge clk);
    s_we = 1'b1; s_ch = ch; s_lo = lo; s_hi = hi;
    @(negedge clk);
    s_we = 1'b0;
  endtask

  initial begin
    // Stream: ch1 -> [100,200], ch2 -> wrap [900,50], ch0 -> [10,20] by
    // a write colliding with a sample. Expectations are hand-computed,
    // enter/exit from the running in_win history of valid results.
    tbl[0]  = row(0, 0,   0,   0, 1,    0, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
    tbl[1]  = row(0, 0,   0,   0, 1,  512, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[2]  = row(0, 0,   0,   0, 1, 1023, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[3]  = row(0, 0,   0,   0, 0,    0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[4]  = row(1, 1, 100, 200, 0,    0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[5]  = row(1, 2, 900,  50, 0,    0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[6]  = row(0, 0,   0,   0, 1,   99, 4'b1001, 4'b0010, 4'b0000, 4'b0000, 4'b0110);
    tbl[7]  = row(0, 0,   0,   0, 1,  100, 4'b1011, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    tbl[8]  = row(0, 0,   0,   0, 1,  200, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[9]  = row(0, 0,   0,   0, 1,  201, 4'b1001, 4'b0000, 4'b0010, 4'b0000, 4'b0010);
    tbl[10] = row(0, 0,   0,   0, 1,   30, 4'b1101, 4'b0010, 4'b0000, 4'b0100, 4'b0000);
    tbl[11] = row(0, 0,   0,   0, 1,  500, 4'b1001, 4'b0000, 4'b0010, 4'b0000, 4'b0100);
    tbl[12] = row(0, 0,   0,   0, 1,  950, 4'b1101, 4'b0000, 4'b0010, 4'b0100, 4'b0000);
    tbl[13] = row(1, 0,  10,  20, 1,    5, 4'b1101, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    tbl[14] = row(0, 0,   0,   0, 0,    0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[15] = row(0, 0,   0,   0, 1,    5, 4'b1100, 4'b0011, 4'b0000, 4'b0000, 4'b0001);
    tbl[16] = row(0, 0,   0,   0, 1,   50, 4'b1100, 4'b0010, 4'b0001, 4'b0000, 4'b0000);
    tbl[17] = row(0, 0,   0,   0, 1,  150, 4'b1010, 4'b0000, 4'b0001, 4'b0010, 4'b0100);
    tbl[18] = row(0, 0,   0,   0, 0,    0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[19] = row(0, 0,   0,   0, 1,  160, 4'b1010, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    tbl[20] = row(0, 0,   0,   0, 1,  250, 4'b1000, 4'b0000, 4'b0011, 4'b0000, 4'b0010);
    tbl[21] = row(0, 0,   0,   0, 1,   80, 4'b1000, 4'b0010, 4'b0001, 4'b0000, 4'b0000);

    // Reset state.
    #12;
    check("reset u out_valid", 32'(u_ov), 32'd0);
    check("reset u in_win",    32'(u_in), 32'd0);
    check("reset s out_valid", 32'(s_ov), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Streamed table: at negedge i the outputs reflect row i-2.
    for (int i = 0; i < NV + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        check($sformatf("row%0d out_valid", i - 2), 32'(u_ov), 32'(tbl[i-2].v));
        check($sformatf("row%0d in_win", i - 2),    32'(u_in), 32'(tbl[i-2].ein));
        check($sformatf("row%0d below", i - 2),     32'(u_bl), 32'(tbl[i-2].ebl));
        check($sformatf("row%0d above", i - 2),     32'(u_ab), 32'(tbl[i-2].eab));
`ifdef WINCMP_EDGE_EN
        check($sformatf("row%0d enter", i - 2),     32'(u_en), 32'(tbl[i-2].een));
        check($sformatf("row%0d exit", i - 2),      32'(u_ex), 32'(tbl[i-2].eex));
`endif
      end
      if (i < NV) begin
        u_we = tbl[i].we; u_ch = tbl[i].ch; u_lo = tbl[i].lo; u_hi = tbl[i].hi;
        u_iv = tbl[i].v;  u_val = tbl[i].val;
      end else begin
        u_we = 1'b0; u_iv = 1'b0;
      end
    end

    // Mid-stream reset: outputs drop at once, bounds return to full range.
    @(negedge clk);
    u_iv = 1'b1; u_val = 10'd150;
    @(negedge clk);
    u_val = 10'd160;
    @(negedge clk);
    u_iv = 1'b0;
    check("pre-reset out_valid", 32'(u_ov), 32'd1);
    check("pre-reset in_win",    32'(u_in), 32'(4'b1010));
    #2 rst_n = 1'b0;
    #1;
    check("async reset out_valid", 32'(u_ov), 32'd0);
    check("async reset in_win",    32'(u_in), 32'd0);
    check("async reset above",     32'(u_ab), 32'd0);
    check("async reset enter",     32'(u_en), 32'd0);
    check("async reset exit",      32'(u_ex), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    u_iv = 1'b1; u_val = 10'd150;
    @(negedge clk);
    u_iv = 1'b0;
    check("post-reset first cycle out_valid", 32'(u_ov), 32'd0);
    @(negedge clk);
    check("post-reset out_valid", 32'(u_ov), 32'd1);
    check("post-reset in_win",    32'(u_in), 32'(4'b1111));
    check("post-reset below",     32'(u_bl), 32'd0);
`ifdef WINCMP_EDGE_EN
    check("post-reset enter",     32'(u_en), 32'(4'b1111));
`endif

    // Signed instance: reset bounds form a full-range wrap window.
    s_sample("s reset -128", 8'h80, 3'b111, 3'b000, 3'b000);
    s_sample("s reset 127",  8'h7F, 3'b111, 3'b000, 3'b000);
    s_write(2'd0, 8'hF6, 8'h05);
    s_sample("s -11", 8'hF5, 3'b110, 3'b001, 3'b000);
    s_sample("s -10", 8'hF6, 3'b111, 3'b000, 3'b000);
    s_sample("s 0",   8'h00, 3'b111, 3'b000, 3'b000);
    s_sample("s 6",   8'h06, 3'b110, 3'b000, 3'b001);
    // Out-of-range channel index must not disturb any channel.
    s_write(2'd3, 8'h10, 8'h20);
    s_sample("s ignored write", 8'h00, 3'b111, 3'b000, 3'b000);
    s_sample("s ch0 kept",      8'hF5, 3'b110, 3'b001, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
